// File: rtl/dpram_rd_pkg.sv
// Shared definitions for the DPRAM line reader.
// Contents:
//   state_t     - control FSM states (IDLE, ISSUE, DRAIN)
//   FIFO_DEPTH  - number of entries in the output skid FIFO
//   fifo_ptr_t  - pointer/count type wide enough for 0..FIFO_DEPTH
//   ptr_inc()   - modulo-FIFO_DEPTH pointer increment
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 3;
    localparam int PTR_W      = 2;

    typedef logic [PTR_W-1:0] fifo_ptr_t;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p);
        return (p == fifo_ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/dpram_line_reader_if.sv
// Valid/ready stream carrying words out of the line reader.
// Signals:
//   m_data  - stream word
//   m_valid - word valid
//   m_ready - downstream can accept
//   m_last  - final word of the burst
// Modports: master (producer side), slave (consumer side).
interface dpram_line_reader_if #(
    parameter int DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/dpram_rd_skid_fifo.sv
// Three-entry synchronous FIFO absorbing RAM read data while the
// downstream stalls.
// Ports:
//   i_clk, i_srst      - clock, synchronous active-high reset (flushes)
//   i_wr_en, i_wr_data - push
//   i_rd_en            - pop the head (ignored when empty)
//   o_head             - head word, forced to zero when empty
//   o_count            - occupancy 0..3
//   o_empty            - no entries
module dpram_rd_skid_fifo
    import dpram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_head,
    output fifo_ptr_t             o_count,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    fifo_ptr_t             r_wr_ptr;
    fifo_ptr_t             r_rd_ptr;
    fifo_ptr_t             r_count;
    logic                  w_rd;
    logic                  w_wr;

    assign w_rd = i_rd_en && (r_count != '0);
    // A push into a full FIFO is only legal when a pop frees a slot in the
    // same cycle; the caller's issue throttle keeps this from happening.
    assign w_wr = i_wr_en && ((r_count != fifo_ptr_t'(FIFO_DEPTH)) || w_rd);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i_srst) begin
                r_mem[i] <= '0;
            end else if (w_wr && (r_wr_ptr == fifo_ptr_t'(i))) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dpram_line_reader.sv
// Reads a burst of consecutive words from the read port of an external
// simple dual-port RAM (one-cycle read latency) and presents them as a
// valid/ready stream with a last-word marker.
// Ports:
//   rd_clk, rd_rst  - clock, synchronous active-high reset
//   start           - one-cycle burst request (only honoured in IDLE)
//   base_addr       - first word address, sampled with start
//   rd_len          - burst length 0..2^ADDR_WIDTH, sampled with start
//   ram_rd_addr     - registered RAM read address
//   ram_rd_data     - RAM read data, one cycle after ram_rd_addr
//   m_if            - output stream (master side)
//   busy            - burst in progress
//   done            - one-cycle pulse after the final word transfers
module dpram_line_reader
    import dpram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   rd_len,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    dpram_line_reader_if.master   m_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_issue_left;
    logic [ADDR_WIDTH:0]   r_xfer_left;
    logic                  r_inflight;
    logic                  r_done;

    fifo_ptr_t             w_fifo_count;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [2:0]            w_occupancy;
    logic                  w_issue;
    logic                  w_pop;

    // Throttle uses only registered state: words already buffered plus the
    // one possibly in flight must leave room, so m_ready never reaches the
    // address path.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_issue     = (r_state == ISSUE) && (w_occupancy <= 3'd2);
    assign w_pop       = m_if.m_valid && m_if.m_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && (rd_len != LEN_ZERO)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue && (r_issue_left == LEN_ONE)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && (r_xfer_left == LEN_ONE)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_xfer_left  <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            r_done     <= 1'b0;

            if ((r_state == IDLE) && start) begin
                if (rd_len != LEN_ZERO) begin
                    r_addr       <= base_addr;
                    r_issue_left <= rd_len;
                    r_xfer_left  <= rd_len;
                end else begin
                    r_done <= 1'b1;
                end
            end

            if (w_issue) begin
                r_addr       <= r_addr + 1'b1;
                r_issue_left <= r_issue_left - 1'b1;
            end

            if (w_pop) begin
                r_xfer_left <= r_xfer_left - 1'b1;
            end

            if ((r_state == DRAIN) && w_pop && (r_xfer_left == LEN_ONE)) begin
                r_done <= 1'b1;
            end
        end
    end

    // Data from an issue made before reset arrives with r_inflight already
    // cleared, so it is never written.
    dpram_rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk     (rd_clk),
        .i_srst    (rd_rst),
        .i_wr_en   (r_inflight),
        .i_wr_data (ram_rd_data),
        .i_rd_en   (w_pop),
        .o_head    (w_head),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    assign ram_rd_addr  = r_addr;
    assign m_if.m_valid = !w_fifo_empty;
    assign m_if.m_data  = w_head;
    assign m_if.m_last  = !w_fifo_empty && (r_xfer_left == LEN_ONE);
    assign busy         = (r_state != IDLE);
    assign done         = r_done;

endmodule

// File: tb/tb_dpram_line_reader.sv
module tb_dpram_line_reader;

    logic        rd_clk;
    logic        rd_rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] rd_len;
    logic [9:0]  ram_rd_addr;
    logic [17:0] ram_rd_data;
    logic        busy;
    logic        done;

    int n_vec;
    int n_err;

    dpram_line_reader_if #(.DATA_WIDTH(18)) m_if ();

    dpram_line_reader #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (18)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .start       (start),
        .base_addr   (base_addr),
        .rd_len      (rd_len),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_if        (m_if),
        .busy        (busy),
        .done        (done)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // RAM content: each word carries its own address so loss, duplication
    // and reordering are all visible.
    function automatic logic [17:0] word(input logic [9:0] a);
        return {8'hC3, a};
    endfunction

    // Simple dual-port RAM read port with one cycle of latency.
    always @(posedge rd_clk) ram_rd_data <= word(ram_rd_addr);

    task automatic test_reset();
        rd_rst = 1'b1; start = 1'b0; base_addr = '0; rd_len = '0; m_if.m_ready = 1'b1;
        repeat (2) @(negedge rd_clk);
        n_vec++;
        if ({ram_rd_addr, m_if.m_valid, m_if.m_last, busy, done, m_if.m_data} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: addr=%0d valid=%b last=%b busy=%b done=%b data=%h, required all zero",
                     ram_rd_addr, m_if.m_valid, m_if.m_last, busy, done, m_if.m_data);
        end
        rd_rst = 1'b0;
        @(negedge rd_clk);
        $display("reset: addr=%0d valid=%b busy=%b done=%b", ram_rd_addr, m_if.m_valid, busy, done);
    endtask

    task automatic test_basic();
        logic exp_valid;
        base_addr = 10'd5; rd_len = 11'd4; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            exp_valid = (c >= 3 && c <= 6);
            if (c <= 4) begin
                n_vec++;
                if (ram_rd_addr !== 10'(4 + c)) begin
                    n_err++;
                    $display("FAIL basic_addr c%0d: got %0d, required %0d", c, ram_rd_addr, 4 + c);
                end
            end
            n_vec++;
            if ({m_if.m_valid, m_if.m_last, busy, done} !== {exp_valid, c == 6, c <= 6, c == 7}) begin
                n_err++;
                $display("FAIL basic_ctrl c%0d: valid/last/busy/done=%b%b%b%b, required %b%b%b%b", c,
                         m_if.m_valid, m_if.m_last, busy, done, exp_valid, c == 6, c <= 6, c == 7);
            end
            if (exp_valid) begin
                n_vec++;
                if (m_if.m_data !== word(10'(2 + c))) begin
                    n_err++;
                    $display("FAIL basic_data c%0d: got %h, required %h", c, m_if.m_data, word(10'(2 + c)));
                end
            end
            $display("basic c%0d: addr=%0d valid=%b data=%h last=%b busy=%b done=%b",
                     c, ram_rd_addr, m_if.m_valid, m_if.m_data, m_if.m_last, busy, done);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_a [4];
        exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
        base_addr = 10'd1022; rd_len = 11'd4; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            if (c <= 4) begin
                n_vec++;
                if (ram_rd_addr !== exp_a[c-1]) begin
                    n_err++;
                    $display("FAIL wrap_addr c%0d: got %0d, required %0d", c, ram_rd_addr, exp_a[c-1]);
                end
            end
            if (c >= 3 && c <= 6) begin
                n_vec++;
                if (m_if.m_valid !== 1'b1 || m_if.m_data !== word(exp_a[c-3])) begin
                    n_err++;
                    $display("FAIL wrap_data c%0d: valid=%b data=%h, required 1 %h",
                             c, m_if.m_valid, m_if.m_data, word(exp_a[c-3]));
                end
            end
            $display("wrap c%0d: addr=%0d valid=%b data=%h", c, ram_rd_addr, m_if.m_valid, m_if.m_data);
        end
    endtask

    task automatic test_stall();
        int got = 0;
        int n_done = 0;
        base_addr = 10'd100; rd_len = 11'd8; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            m_if.m_ready = !(c >= 4 && c <= 7);
            if (c >= 4 && c <= 7) begin
                n_vec++;
                if (m_if.m_valid !== 1'b1 || m_if.m_data !== word(10'(100 + got))) begin
                    n_err++;
                    $display("FAIL stall_hold c%0d: valid=%b data=%h, required 1 %h",
                             c, m_if.m_valid, m_if.m_data, word(10'(100 + got)));
                end
            end
            if (c >= 5 && c <= 9) begin
                n_vec++;
                if (ram_rd_addr !== 10'd104) begin
                    n_err++;
                    $display("FAIL stall_throttle c%0d: addr=%0d, required 104", c, ram_rd_addr);
                end
            end
            if (m_if.m_valid && m_if.m_ready) begin
                n_vec++;
                if (m_if.m_data !== word(10'(100 + got)) || m_if.m_last !== (got == 7)) begin
                    n_err++;
                    $display("FAIL stall_word %0d: data=%h last=%b, required %h %b",
                             got, m_if.m_data, m_if.m_last, word(10'(100 + got)), got == 7);
                end
                got++;
            end
            if (done) n_done++;
            $display("stall c%0d: addr=%0d valid=%b ready=%b data=%h last=%b done=%b",
                     c, ram_rd_addr, m_if.m_valid, m_if.m_ready, m_if.m_data, m_if.m_last, done);
        end
        n_vec++;
        if (got != 8 || n_done != 1) begin
            n_err++;
            $display("FAIL stall_total: words=%0d done_pulses=%0d, required 8 1", got, n_done);
        end
    endtask

    task automatic test_zero_len();
        base_addr = 10'd50; rd_len = 11'd0; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            n_vec++;
            if ({done, m_if.m_valid, busy} !== {c == 1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL zero_len c%0d: done/valid/busy=%b%b%b, required %b00",
                         c, done, m_if.m_valid, busy, c == 1);
            end
            $display("zero c%0d: done=%b valid=%b busy=%b", c, done, m_if.m_valid, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got = 0;
        int n_done = 0;
        base_addr = 10'd200; rd_len = 11'd16; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
        end
        rd_rst = 1'b1;
        @(negedge rd_clk);
        n_vec++;
        if ({ram_rd_addr, m_if.m_valid, m_if.m_last, busy, done, m_if.m_data} !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_state: addr=%0d valid=%b last=%b busy=%b done=%b data=%h, required all zero",
                     ram_rd_addr, m_if.m_valid, m_if.m_last, busy, done, m_if.m_data);
        end
        $display("midrst: addr=%0d valid=%b busy=%b", ram_rd_addr, m_if.m_valid, busy);
        rd_rst = 1'b0;
        base_addr = 10'd300; rd_len = 11'd3; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge rd_clk);
            start = 1'b0;
            if (m_if.m_valid && m_if.m_ready) begin
                n_vec++;
                if (m_if.m_data !== word(10'(300 + got)) || m_if.m_last !== (got == 2)) begin
                    n_err++;
                    $display("FAIL midrst_word %0d: data=%h last=%b, required %h %b",
                             got, m_if.m_data, m_if.m_last, word(10'(300 + got)), got == 2);
                end
                got++;
            end
            if (done) n_done++;
            $display("post-rst c%0d: valid=%b data=%h last=%b done=%b", c, m_if.m_valid, m_if.m_data, m_if.m_last, done);
        end
        n_vec++;
        if (got != 3 || n_done != 1) begin
            n_err++;
            $display("FAIL midrst_total: words=%0d done_pulses=%0d, required 3 1", got, n_done);
        end
    endtask

    task automatic test_start_while_busy();
        int got = 0;
        int n_done = 0;
        base_addr = 10'd400; rd_len = 11'd3; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge rd_clk);
            start = (c == 2);
            if (c == 2) begin
                base_addr = 10'd500; rd_len = 11'd5;
            end
            if (m_if.m_valid && m_if.m_ready) begin
                n_vec++;
                if (got >= 3 || m_if.m_data !== word(10'(400 + got))) begin
                    n_err++;
                    $display("FAIL busy_start_word %0d: data=%h, required %h and at most 3 words",
                             got, m_if.m_data, word(10'(400 + got)));
                end
                got++;
            end
            if (done) n_done++;
            $display("busy-start c%0d: addr=%0d valid=%b data=%h busy=%b done=%b",
                     c, ram_rd_addr, m_if.m_valid, m_if.m_data, busy, done);
        end
        n_vec++;
        if (got != 3 || n_done != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_total: words=%0d done_pulses=%0d busy=%b, required 3 1 0", got, n_done, busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_reset_mid_burst();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_line_reader.md
DPRAM_LINE_READER -- requirements
Module: dpram_line_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 18, RAM word width.
REQ-003 The block SHALL have port rd_clk  input  1  the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rd_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to read a burst.
REQ-006 The block SHALL have port base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-007 The block SHALL have port rd_len  input  ADDR_WIDTH+1  burst length in words, 0..2^ADDR_WIDTH, sampled with start.
REQ-008 The block SHALL have port ram_rd_addr  output  ADDR_WIDTH  read address to the simple dual-port RAM read port.
REQ-009 The block SHALL have port ram_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_addr, unregistered output.
REQ-010 The block SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-011 The block SHALL have port m_valid  output  1  stream data valid.
REQ-012 The block SHALL have port m_ready  input  1  downstream ready.
REQ-013 The block SHALL have port m_last  output  1  marks final word of burst.
REQ-014 The block SHALL have port busy  output  1  high from start acceptance until done.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN.
REQ-017 In IDLE, start=1 with rd_len>0 SHALL latch base_addr/rd_len and go to ISSUE; with rd_len=0 it SHALL stay IDLE and pulse done next cycle, no stream output.
REQ-018 start SHALL be ignored while not in IDLE.
REQ-019 A read SHALL be issued in a cycle when in ISSUE and fifo_count+inflight <= 2, from registered state only, with no combinational path from m_ready to ram_rd_addr.
REQ-020 ram_rd_addr SHALL be registered; each issue SHALL increment it modulo 2^ADDR_WIDTH, so 1023 wraps to 0 at default width.
REQ-021 inflight SHALL be a 1-bit delayed issue flag; when set, ram_rd_data SHALL be written into a 3-entry FIFO that same cycle.
REQ-022 After issuing rd_len reads, the FSM SHALL move to DRAIN; when the last word transfers, it SHALL return to IDLE and pulse done in the following cycle.
REQ-023 m_valid SHALL equal FIFO non-empty, and m_data SHALL be the FIFO head; a transfer SHALL occur when m_valid && m_ready.
REQ-024 m_valid SHALL NOT drop and m_data SHALL NOT change while m_valid=1 and m_ready=0.
REQ-025 m_last SHALL be high exactly with the rd_len-th word at the FIFO head.
REQ-026 Latency SHALL be: start at cycle 0, first address at cycle 1, first m_valid at cycle 3.
REQ-027 With m_ready held high, the block SHALL sustain one word per cycle.
REQ-028 A simultaneous FIFO write and pop SHALL keep the count unchanged.
REQ-029 busy SHALL be high in ISSUE and DRAIN.

Reset
REQ-030 rd_rst=1 SHALL force IDLE, flush the FIFO and clear inflight, and drive ram_rd_addr=0, m_valid=0, m_last=0, busy=0, done=0, m_data=0 at the next edge, including mid-burst.
REQ-031 Data returning from an issue made before reset SHALL be discarded.

Structure
REQ-032 Package dpram_rd_pkg SHALL hold the FSM state enum and constant FIFO_DEPTH=3.
REQ-033 The FIFO SHALL be sub-module dpram_rd_skid_fifo (synchronous, 3 entries, count output); the RAM SHALL NOT be instantiated inside this block.

Verification
REQ-034 base_addr=5, rd_len=4, m_ready=1 -> addresses 5,6,7,8 on cycles 1-4; data at m_valid on cycles 3-6; m_last on cycle 6; done on cycle 7.
REQ-035 base_addr=1022, rd_len=4 -> addresses 1022,1023,0,1 in order.
REQ-036 rd_len=8 with m_ready low on cycles 4-7 -> at most 3 words buffered, no loss or duplication, m_data stable while stalled.
REQ-037 rd_len=0 -> done pulse one cycle after start, m_valid never asserted, busy stays low.
REQ-038 rd_rst pulsed mid-burst of rd_len=16 -> all outputs 0 next cycle; a new start then yields a clean burst with no stale words.
REQ-039 start pulsed again while busy -> ignored, and only the first burst's words appear.
